// File: rtl/ifetch.sv
// Instruction fetch stage: drives instruction-memory reads, owns the PC and the IF/ID register,
// and handles branch delay slots, pipeline pauses and software interrupts/ERET.
module ifetch #(
  parameter logic [15:0] INT_VECTOR = 16'h0008,
  parameter logic [15:0] NOP_INSTR  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifi_branch,
  input  logic [15:0] ifi_new_pc,
  input  logic        ifi_pause,
  input  logic        ifi_int,
  input  logic [3:0]  ifi_int_id,
  input  logic        ifi_int_en_set,
  input  logic        ifi_int_en_clr,
  output logic        ifo_mem_req,
  output logic [15:0] ifo_mem_addr,
  input  logic        ifi_mem_ack,
  input  logic [15:0] ifi_mem_data,
  output logic [15:0] ifo_addr,
  output logic [15:0] ifo_instr,
  output logic [7:0]  ifo_cause,
  output logic        ifo_int_en,
  output logic [15:0] ifo_epc
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [15:0] ifid_addr, ifid_addr_nx;
  logic [15:0] ifid_instr, ifid_instr_nx;
  logic [15:0] hold_addr, hold_addr_nx;
  logic [15:0] hold_data, hold_data_nx;
  logic        pend_valid, pend_valid_nx;
  logic [15:0] pend_target, pend_target_nx;
  logic [15:0] epc, epc_nx;
  logic [3:0]  cause_id, cause_id_nx;
  logic        int_en, int_en_nx;
  logic        commit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_REQ;
      pc          <= 16'h0000;
      ifid_addr   <= 16'h0000;
      ifid_instr  <= NOP_INSTR;
      hold_addr   <= 16'h0000;
      hold_data   <= 16'h0000;
      pend_valid  <= 1'b0;
      pend_target <= 16'h0000;
      epc         <= 16'h0000;
      cause_id    <= 4'h0;
      int_en      <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      ifid_addr   <= ifid_addr_nx;
      ifid_instr  <= ifid_instr_nx;
      hold_addr   <= hold_addr_nx;
      hold_data   <= hold_data_nx;
      pend_valid  <= pend_valid_nx;
      pend_target <= pend_target_nx;
      epc         <= epc_nx;
      cause_id    <= cause_id_nx;
      int_en      <= int_en_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    ifid_addr_nx   = ifid_addr;
    ifid_instr_nx  = ifid_instr;
    hold_addr_nx   = hold_addr;
    hold_data_nx   = hold_data;
    pend_valid_nx  = pend_valid;
    pend_target_nx = pend_target;
    epc_nx         = epc;
    cause_id_nx    = cause_id;
    int_en_nx      = int_en;
    commit         = 1'b0;

    if (ifi_int_en_clr)      int_en_nx = 1'b0;
    else if (ifi_int_en_set) int_en_nx = 1'b1;

    if (ifi_pause) begin
      // Branch/int are ignored here; ID keeps presenting them until the pause lifts.
      if (state == S_REQ && ifi_mem_ack) begin
        hold_addr_nx = pc;
        hold_data_nx = ifi_mem_data;
        state_nx     = S_HOLD;
      end
    end else if (ifi_int) begin
      ifid_addr_nx  = pc;
      ifid_instr_nx = NOP_INSTR;
      state_nx      = S_REQ;
      pend_valid_nx = 1'b0;
      hold_addr_nx  = 16'h0000;
      hold_data_nx  = 16'h0000;
      if (ifi_int_id == 4'hF) begin
        pc_nx     = epc;
        int_en_nx = 1'b1;
      end else begin
        epc_nx      = ifid_addr + 16'd1;
        cause_id_nx = ifi_int_id;
        int_en_nx   = 1'b0;
        pc_nx       = INT_VECTOR;
      end
    end else begin
      if (state == S_HOLD) begin
        ifid_addr_nx  = hold_addr;
        ifid_instr_nx = hold_data;
        state_nx      = S_REQ;
        hold_addr_nx  = 16'h0000;
        hold_data_nx  = 16'h0000;
        commit        = 1'b1;
      end else if (ifi_mem_ack) begin
        ifid_addr_nx  = pc;
        ifid_instr_nx = ifi_mem_data;
        commit        = 1'b1;
      end else begin
        ifid_addr_nx  = pc;
        ifid_instr_nx = NOP_INSTR;
      end

      // The delay-slot word must commit before the redirect takes effect.
      if (commit) begin
        if (ifi_branch)      pc_nx = ifi_new_pc;
        else if (pend_valid) pc_nx = pend_target;
        else                 pc_nx = pc + 16'd1;
        pend_valid_nx = 1'b0;
      end else if (ifi_branch) begin
        pend_valid_nx  = 1'b1;
        pend_target_nx = ifi_new_pc;
      end
    end
  end

  assign ifo_mem_req  = rst && (state == S_REQ);
  assign ifo_mem_addr = pc;
  assign ifo_addr     = ifid_addr;
  assign ifo_instr    = ifid_instr;
  assign ifo_cause    = {4'h0, cause_id};
  assign ifo_int_en   = int_en;
  assign ifo_epc      = epc;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: memory returns 0x1000+addr; expected IF/ID contents are queued
// when a step is driven and popped after the clock edge.
module tb_ifetch;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, pause, int_req, en_set, en_clr, ack;
  logic [15:0] new_pc;
  logic [3:0]  int_id;
  logic        mem_req;
  logic [15:0] mem_addr, mem_data, addr, instr, epc;
  logic [7:0]  cause;
  logic        int_en;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_data = 16'h1000 + mem_addr;

  ifetch #(.INT_VECTOR(16'h0008), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .ifi_branch(branch), .ifi_new_pc(new_pc), .ifi_pause(pause),
    .ifi_int(int_req), .ifi_int_id(int_id),
    .ifi_int_en_set(en_set), .ifi_int_en_clr(en_clr),
    .ifo_mem_req(mem_req), .ifo_mem_addr(mem_addr),
    .ifi_mem_ack(ack), .ifi_mem_data(mem_data),
    .ifo_addr(addr), .ifo_instr(instr),
    .ifo_cause(cause), .ifo_int_en(int_en), .ifo_epc(epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_addr"}, {16'h0, addr}, {16'h0, e.addr});
      check({tag, "_instr"}, {16'h0, instr}, {16'h0, e.instr});
    end
  endtask

  // One clock: request checked mid-cycle, IF/ID checked just after the edge, pulses then dropped.
  task automatic applyStimulus(input string tag, input logic exp_req, input logic [15:0] exp_maddr,
                               input logic [15:0] exp_addr, input logic [15:0] exp_instr);
    exp_t e;
    e.addr  = exp_addr;
    e.instr = exp_instr;
    sb.push_back(e);
    @(negedge clk);
    check({tag, "_req"}, {31'h0, mem_req}, {31'h0, exp_req});
    if (exp_req) check({tag, "_maddr"}, {16'h0, mem_addr}, {16'h0, exp_maddr});
    @(posedge clk);
    #1;
    branch  = 1'b0;
    int_req = 1'b0;
    en_set  = 1'b0;
    en_clr  = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; branch = 1'b0; pause = 1'b0; int_req = 1'b0; int_id = 4'h0;
    en_set = 1'b0; en_clr = 1'b0; ack = 1'b0; new_pc = 16'h0000;
    #2 rst = 1'b0;
    #1;
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_addr", {16'h0, addr}, 32'h0);
    check("rst_instr", {16'h0, instr}, {16'h0, NOP});
    check("rst_epc", {16'h0, epc}, 32'h0);
    check("rst_cause", {24'h0, cause}, 32'h0);
    check("rst_int_en", {31'h0, int_en}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    ack = 1'b1;
    for (int k = 0; k < 5; k++)
      applyStimulus("seq", 1'b1, 16'(k), 16'(k), 16'h1000 + 16'(k));

    ack = 1'b0;
    repeat (3) applyStimulus("bubble", 1'b1, 16'h0005, 16'h0005, NOP);
    ack = 1'b1;
    applyStimulus("bubble_end", 1'b1, 16'h0005, 16'h0005, 16'h1005);
    ack = 1'b0; pause = 1'b1;
    applyStimulus("pause_noack", 1'b1, 16'h0006, 16'h0005, 16'h1005);
    ack = 1'b1; pause = 1'b0;
    applyStimulus("seq6", 1'b1, 16'h0006, 16'h0006, 16'h1006);

    pause = 1'b1;
    applyStimulus("pause_ack", 1'b1, 16'h0007, 16'h0006, 16'h1006);
    applyStimulus("pause_hold", 1'b0, 16'h0000, 16'h0006, 16'h1006);
    pause = 1'b0;
    applyStimulus("hold_rel", 1'b0, 16'h0000, 16'h0007, 16'h1007);
    applyStimulus("after_hold", 1'b1, 16'h0008, 16'h0008, 16'h1008);

    ack = 1'b0; branch = 1'b1; new_pc = 16'h0040;
    applyStimulus("br_wait1", 1'b1, 16'h0009, 16'h0009, NOP);
    applyStimulus("br_wait2", 1'b1, 16'h0009, 16'h0009, NOP);
    ack = 1'b1;
    applyStimulus("br_slot", 1'b1, 16'h0009, 16'h0009, 16'h1009);
    applyStimulus("br_target", 1'b1, 16'h0040, 16'h0040, 16'h1040);

    branch = 1'b1; new_pc = 16'h0020; en_set = 1'b1;
    applyStimulus("br_20", 1'b1, 16'h0041, 16'h0041, 16'h1041);
    check("en_set", {31'h0, int_en}, 32'h1);
    applyStimulus("at_20", 1'b1, 16'h0020, 16'h0020, 16'h1020);
    int_req = 1'b1; int_id = 4'h3;
    applyStimulus("int3", 1'b1, 16'h0021, 16'h0021, NOP);
    check("int_epc", {16'h0, epc}, 32'h0021);
    check("int_cause", {24'h0, cause}, 32'h03);
    check("int_en_off", {31'h0, int_en}, 32'h0);
    applyStimulus("vector", 1'b1, 16'h0008, 16'h0008, 16'h1008);
    int_req = 1'b1; int_id = 4'hF;
    applyStimulus("eret", 1'b1, 16'h0009, 16'h0009, NOP);
    check("eret_en", {31'h0, int_en}, 32'h1);
    applyStimulus("eret_ret", 1'b1, 16'h0021, 16'h0021, 16'h1021);

    ack = 1'b0; en_set = 1'b1; en_clr = 1'b1;
    applyStimulus("setclr", 1'b1, 16'h0022, 16'h0022, NOP);
    check("clr_wins", {31'h0, int_en}, 32'h0);
    en_set = 1'b1;
    applyStimulus("set_again", 1'b1, 16'h0022, 16'h0022, NOP);
    check("en_set2", {31'h0, int_en}, 32'h1);

    ack = 1'b1; branch = 1'b1; new_pc = 16'hFFFF;
    applyStimulus("br_ffff", 1'b1, 16'h0022, 16'h0022, 16'h1022);
    applyStimulus("at_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 16'h0FFF);
    applyStimulus("wrap", 1'b1, 16'h0000, 16'h0000, 16'h1000);

    ack = 1'b0;
    @(negedge clk);
    check("mid_req", {31'h0, mem_req}, 32'h1);
    check("mid_maddr", {16'h0, mem_addr}, 32'h0001);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, mem_req}, 32'h0);
    check("mid_rst_addr", {16'h0, addr}, 32'h0);
    check("mid_rst_instr", {16'h0, instr}, {16'h0, NOP});
    check("mid_rst_int_en", {31'h0, int_en}, 32'h0);
    check("mid_rst_epc", {16'h0, epc}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    ack = 1'b1;
    applyStimulus("restart", 1'b1, 16'h0000, 16'h0000, 16'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  INT_VECTOR  16'h0008  PC target for a taken software interrupt
  NOP_INSTR   16'h0800  bubble encoding placed in IF/ID
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ifi_branch  in  1  ID redirect request.
REQ-005 ifi_new_pc  in  16  branch target from ID.
REQ-006 ifi_pause  in  1  pipeline stall; freezes PC and IF/ID.
REQ-007 ifi_int  in  1  software interrupt or ERET from ID.
REQ-008 ifi_int_id  in  4  interrupt number; 4'hF = ERET.
REQ-009 ifi_int_en_set / ifi_int_en_clr  in  1 each  interrupt-enable set/clear pulses.
REQ-010 ifo_mem_req  out  1  instruction-memory read request.
REQ-011 ifo_mem_addr  out  16  read address (= PC).
REQ-012 ifi_mem_ack  in  1  read data valid this cycle.
REQ-013 ifi_mem_data  in  16  instruction word.
REQ-014 ifo_addr / ifo_instr  out  16 each  IF/ID register contents to ID.
REQ-015 ifo_cause  out  8  {4'h0, last interrupt id}.
REQ-016 ifo_int_en  out  1  interrupt-enable flag.
REQ-017 ifo_epc  out  16  saved return address.

Function
REQ-018 States: S_REQ (request outstanding) and S_HOLD (fetched word buffered during pause).
REQ-019 S_REQ: ifo_mem_req=1, ifo_mem_addr=PC; S_HOLD: ifo_mem_req=0.
REQ-020 S_REQ, ack=1, pause=0: IF/ID <= (PC, mem_data); PC <= next PC.
REQ-021 S_REQ, ack=0, pause=0: IF/ID <= (PC, NOP_INSTR); PC unchanged.
REQ-022 S_REQ, ack=1, pause=1: word and PC go to hold buffer; IF/ID unchanged; go S_HOLD.
REQ-023 S_REQ, ack=0, pause=1: IF/ID and PC unchanged; stay S_REQ.
REQ-024 S_HOLD, pause=1: everything unchanged. S_HOLD, pause=0: IF/ID <= buffer; PC <= next PC; go S_REQ.
REQ-025 Next PC = PC+1 (16-bit wrap, 16'hFFFF -> 16'h0000) unless a redirect applies.
REQ-026 Branch has one delay slot: the fetch in progress when ifi_branch=1 completes normally; following fetch is from ifi_new_pc.
REQ-027 If ifi_branch=1 and the delay-slot word is not committed this cycle, target is latched into a pending-redirect register; PC <= target on the cycle that word commits; pending cleared.
REQ-028 ifi_int=1, id!=4'hF: epc <= ifo_addr+1; cause <= {4'h0, id}; int_en <= 0; PC <= INT_VECTOR; in-flight fetch discarded (IF/ID <= NOP, state S_REQ); pending redirect and hold buffer cleared.
REQ-029 ifi_int=1, id==4'hF (ERET): PC <= epc; int_en <= 1; in-flight fetch discarded as REQ-028.
REQ-030 Priority: pause > int > branch > sequential; ifi_branch and ifi_int ignored while pause=1 (ID re-presents them).
REQ-031 int_en_set and int_en_clr same cycle: clear wins; REQ-028/029 updates override both.
REQ-032 A discarded request whose ack arrives later is not used; ack is honoured only in S_REQ for the current PC.

Reset
REQ-033 rst=0 forces immediately: PC=0, state S_REQ, ifo_mem_req=0 during reset, IF/ID=(16'h0000, NOP_INSTR), epc=0, cause=0, int_en=0, pending redirect cleared, hold buffer cleared.
REQ-034 Reset asserted mid-fetch abandons the request; first request after release is address 16'h0000.

Verification
REQ-035 Ack every cycle, words 0x1000+n -> ifo_instr 0x1000,0x1001,... with ifo_addr 0,1,2 one cycle after each ack.
REQ-036 Ack withheld 3 cycles at PC=5 -> three NOP_INSTR bubbles, ifo_mem_addr stays 5, then addr 5 committed.
REQ-037 Pause on ack of addr 7 for 2 cycles -> IF/ID frozen, req=0, addr 7 word appears on release, next fetch addr 8.
REQ-038 Branch to 0x0040 with delay-slot ack delayed 2 cycles -> delay slot committed, then fetch addr 0x0040.
REQ-039 INT id=3 while ifo_addr=0x0020, int_en=1 -> epc=0x0021, cause=0x03, int_en=0, next fetch 0x0008; ERET -> fetch 0x0021, int_en=1.
REQ-040 Counter at PC=16'hFFFF, ack -> next ifo_mem_addr=16'h0000; rst pulse mid-request -> req drops, restart at 0.
